// File: rtl/aes_core_ctrl.sv
// Sequencing controller for the AES-128 datapath: accepts one plaintext block,
// walks LOAD and rounds 0..NUM_ROUNDS, then holds the result until it is accepted.
module aes_core_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid_in,
  output logic                  start_ready_out,
  input  logic [DATA_WIDTH-1:0] text_0_in,
  input  logic [DATA_WIDTH-1:0] text_1_in,
  input  logic [DATA_WIDTH-1:0] text_2_in,
  input  logic [DATA_WIDTH-1:0] text_3_in,
  output logic [DATA_WIDTH-1:0] text_0_out,
  output logic [DATA_WIDTH-1:0] text_1_out,
  output logic [DATA_WIDTH-1:0] text_2_out,
  output logic [DATA_WIDTH-1:0] text_3_out,
  input  logic                  key_ready_in,
  output logic [3:0]            key_idx_out,
  output logic [2:0]            FSM_core_out,
  output logic [3:0]            core_count_out,
  input  logic                  cipher_dv_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  input  logic                  abort_in,
  output logic                  busy_out,
  output logic                  key_err_out,
  output logic [CNT_WIDTH-1:0]  blocks_done_out
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'b000,
    ST_KEY_WAIT = 3'b001,
    ST_LOAD     = 3'b010,
    ST_ROUND    = 3'b011,
    ST_DONE     = 3'b100
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t                state_r;
  logic [3:0]            count_r;
  logic                  start_ready_r;
  logic                  out_valid_r;
  logic                  busy_r;
  logic                  key_err_r;
  logic [CNT_WIDTH-1:0]  blocks_r;
  logic [DATA_WIDTH-1:0] text0_r;
  logic [DATA_WIDTH-1:0] text1_r;
  logic [DATA_WIDTH-1:0] text2_r;
  logic [DATA_WIDTH-1:0] text3_r;
  logic                  unused_dv_s;

  // The datapath's result-valid flag is only cross-checked externally.
  assign unused_dv_s = cipher_dv_in;

  // Controller FSM with its registered handshake, status and hold outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      count_r       <= 4'd0;
      start_ready_r <= 1'b1;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      key_err_r     <= 1'b0;
      blocks_r      <= '0;
      text0_r       <= '0;
      text1_r       <= '0;
      text2_r       <= '0;
      text3_r       <= '0;
    end else if (abort_in) begin
      state_r       <= ST_IDLE;
      count_r       <= 4'd0;
      start_ready_r <= 1'b1;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      key_err_r     <= 1'b0;
    end else begin
      // A key store that goes unstable mid-cipher poisons this block's result.
      if ((state_r == ST_LOAD || state_r == ST_ROUND) && !key_ready_in) begin
        key_err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_valid_in && start_ready_r) begin
            text0_r       <= text_0_in;
            text1_r       <= text_1_in;
            text2_r       <= text_2_in;
            text3_r       <= text_3_in;
            start_ready_r <= 1'b0;
            busy_r        <= 1'b1;
            count_r       <= 4'd0;
            state_r       <= key_ready_in ? ST_LOAD : ST_KEY_WAIT;
          end
        end
        ST_KEY_WAIT: begin
          if (key_ready_in) begin
            state_r <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count_r <= 4'd0;
          state_r <= ST_ROUND;
        end
        ST_ROUND: begin
          if (count_r == LAST_ROUND) begin
            count_r     <= 4'd0;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            count_r <= count_r + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready_in) begin
            blocks_r      <= blocks_r + CNT_WIDTH'(1);
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            start_ready_r <= 1'b1;
            state_r       <= ST_IDLE;
          end
        end
        default: begin
          count_r       <= 4'd0;
          out_valid_r   <= 1'b0;
          busy_r        <= 1'b0;
          start_ready_r <= 1'b1;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_ready_out = start_ready_r;
  assign out_valid_out   = out_valid_r;
  assign busy_out        = busy_r;
  assign key_err_out     = key_err_r;
  assign blocks_done_out = blocks_r;
  assign FSM_core_out    = state_r;
  assign core_count_out  = count_r;
  assign key_idx_out     = count_r;
  assign text_0_out      = text0_r;
  assign text_1_out      = text1_r;
  assign text_2_out      = text2_r;
  assign text_3_out      = text3_r;

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Directed bench for aes_core_ctrl: a timeline model checks every cycle, and
// literal expectations pin latency, backpressure, abort, key error and wrap.
module tb_aes_core_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic [31:0] t0 = 32'd0, t1 = 32'd0, t2 = 32'd0, t3 = 32'd0;
  logic        key_ready = 1'b1;
  logic        out_ready = 1'b0;
  logic        abort = 1'b0;
  logic        cipher_dv;

  logic        start_ready, out_valid, busy, key_err;
  logic [31:0] to0, to1, to2, to3;
  logic [3:0]  key_idx, core_count;
  logic [2:0]  fsm;
  logic [15:0] blocks;

  logic        s_start_ready, s_out_valid, s_busy, s_key_err;
  logic [31:0] s_to0, s_to1, s_to2, s_to3;
  logic [3:0]  s_key_idx, s_core_count;
  logic [2:0]  s_fsm;
  logic [3:0]  s_blocks;

  int n_checks = 0;
  int n_pass = 0;

  localparam int M_IDLE = 0, M_WAITKEY = 1, M_RUN = 2, M_DONE = 3;
  int          m_mode;
  int          m_cyc;
  logic        m_kerr;
  int          m_blocks;
  logic [31:0] m_text [4];

  always #5 clk = ~clk;

  // The bench stands in for the datapath: its valid flag follows the model's DONE phase.
  assign cipher_dv = (m_mode == M_DONE);

  aes_core_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(16), .NUM_ROUNDS(10)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid_in(start_valid), .start_ready_out(start_ready),
    .text_0_in(t0), .text_1_in(t1), .text_2_in(t2), .text_3_in(t3),
    .text_0_out(to0), .text_1_out(to1), .text_2_out(to2), .text_3_out(to3),
    .key_ready_in(key_ready), .key_idx_out(key_idx), .FSM_core_out(fsm),
    .core_count_out(core_count), .cipher_dv_in(cipher_dv), .out_valid_out(out_valid),
    .out_ready_in(out_ready), .abort_in(abort), .busy_out(busy), .key_err_out(key_err),
    .blocks_done_out(blocks)
  );

  // Narrow counter instance so wrap-around is reachable in a short run.
  aes_core_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(4), .NUM_ROUNDS(10)) dut_small (
    .clk(clk), .rst_n(rst_n), .start_valid_in(start_valid), .start_ready_out(s_start_ready),
    .text_0_in(t0), .text_1_in(t1), .text_2_in(t2), .text_3_in(t3),
    .text_0_out(s_to0), .text_1_out(s_to1), .text_2_out(s_to2), .text_3_out(s_to3),
    .key_ready_in(key_ready), .key_idx_out(s_key_idx), .FSM_core_out(s_fsm),
    .core_count_out(s_core_count), .cipher_dv_in(cipher_dv), .out_valid_out(s_out_valid),
    .out_ready_in(out_ready), .abort_in(abort), .busy_out(s_busy), .key_err_out(s_key_err),
    .blocks_done_out(s_blocks)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [2:0] exp_code();
    case (m_mode)
      M_IDLE:    return 3'b000;
      M_WAITKEY: return 3'b001;
      M_RUN:     return (m_cyc == 0) ? 3'b010 : 3'b011;
      default:   return 3'b100;
    endcase
  endfunction

  function automatic logic [3:0] exp_count();
    return (m_mode == M_RUN && m_cyc > 0) ? 4'(m_cyc - 1) : 4'd0;
  endfunction

  // Model: m_cyc counts cycles since LOAD; rounds occupy m_cyc 1..11.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_mode = M_IDLE; m_cyc = 0; m_kerr = 1'b0; m_blocks = 0;
        for (int i = 0; i < 4; i++) m_text[i] = 32'd0;
      end else if (abort) begin
        m_mode = M_IDLE; m_cyc = 0; m_kerr = 1'b0;
      end else begin
        case (m_mode)
          M_IDLE: if (start_valid) begin
            m_text[0] = t0; m_text[1] = t1; m_text[2] = t2; m_text[3] = t3;
            m_cyc = 0;
            m_mode = key_ready ? M_RUN : M_WAITKEY;
          end
          M_WAITKEY: if (key_ready) begin
            m_cyc = 0; m_mode = M_RUN;
          end
          M_RUN: begin
            if (!key_ready) m_kerr = 1'b1;
            if (m_cyc == 11) m_mode = M_DONE;
            else m_cyc++;
          end
          default: if (out_ready) begin
            m_blocks++; m_mode = M_IDLE;
          end
        endcase
      end
      #1;
      chk("fsm", fsm, exp_code());
      chk("core_count", core_count, exp_count());
      chk("key_idx", key_idx, exp_count());
      chk("start_ready", start_ready, m_mode == M_IDLE);
      chk("busy", busy, m_mode != M_IDLE);
      chk("out_valid", out_valid, m_mode == M_DONE);
      chk("dv_xcheck", out_valid, cipher_dv);
      chk("key_err", key_err, m_kerr);
      chk("blocks", blocks, 16'(m_blocks));
      chk("text_out", {to0, to1, to2, to3}, {m_text[0], m_text[1], m_text[2], m_text[3]});
      chk("small_outs",
          {s_fsm, s_core_count, s_key_idx, s_start_ready, s_busy, s_out_valid, s_key_err, s_blocks,
           s_to0, s_to1, s_to2, s_to3},
          {exp_code(), exp_count(), exp_count(), m_mode == M_IDLE, m_mode != M_IDLE,
           m_mode == M_DONE, m_kerr, 4'(m_blocks), m_text[0], m_text[1], m_text[2], m_text[3]});
    end
  end

  task automatic send(input logic [127:0] blk);
    @(negedge clk);
    {t0, t1, t2, t3} = blk;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_code(input logic [2:0] code, input int limit);
    int n = 0;
    while (fsm !== code && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_code", fsm, code);
  endtask

  task automatic wait_round(input logic [3:0] r, input int limit);
    int n = 0;
    while (!(fsm === 3'b011 && core_count === r) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_round", {fsm, core_count}, {3'b011, r});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_fsm", fsm, 3'b000);
    chk("idle_ready", start_ready, 1'b1);
    chk("idle_blocks", blocks, 16'd0);

    // Block A: key ready, out_ready already high before DONE.
    out_ready = 1'b1;
    send(128'h00112233_44556677_8899aabb_ccddeeff);
    chk("a_load", fsm, 3'b010);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("a_round", {fsm, core_count, key_idx}, {3'b011, 4'(i), 4'(i)});
    end
    @(negedge clk);
    chk("a_done", {fsm, out_valid}, {3'b100, 1'b1});
    @(negedge clk);
    chk("a_idle", {fsm, blocks}, {3'b000, 16'd1});
    chk("a_text", {to0, to1, to2, to3}, 128'h00112233_44556677_8899aabb_ccddeeff);

    // Block B: key wait of five cycles, then seven cycles of backpressure.
    key_ready = 1'b0;
    out_ready = 1'b0;
    send(128'hcafef00d_01234567_89abcdef_a5a5a5a5);
    {t0, t1, t2, t3} = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    for (int i = 0; i < 5; i++) begin
      chk("b_keywait", {fsm, start_ready}, {3'b001, 1'b0});
      if (i < 4) @(negedge clk);
    end
    key_ready = 1'b1;
    @(negedge clk);
    chk("b_load", fsm, 3'b010);
    chk("b_text", {to0, to1, to2, to3}, 128'hcafef00d_01234567_89abcdef_a5a5a5a5);
    wait_code(3'b100, 20);
    for (int i = 0; i < 7; i++) begin
      chk("b_hold", {fsm, out_valid, blocks}, {3'b100, 1'b1, 16'd1});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("b_accept", {fsm, blocks}, {3'b000, 16'd2});

    // Block C: abort at round 6.
    send(128'h11111111_22222222_33333333_44444444);
    wait_round(4'd6, 20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("c_abort", {fsm, core_count, out_valid, blocks}, {3'b000, 4'd0, 1'b0, 16'd2});
    chk("c_text", to0, 32'h11111111);

    // Block D completes normally after the abort.
    send(128'h55555555_66666666_77777777_88888888);
    wait_code(3'b100, 20);
    @(negedge clk);
    chk("d_blocks", blocks, 16'd3);

    // Block E: key store drops for one cycle in round 3.
    send(128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc);
    wait_round(4'd3, 20);
    key_ready = 1'b0;
    @(negedge clk);
    key_ready = 1'b1;
    chk("e_err_set", key_err, 1'b1);
    wait_code(3'b100, 20);
    chk("e_err_done", key_err, 1'b1);
    @(negedge clk);
    chk("e_err_idle", {fsm, key_err, blocks}, {3'b000, 1'b1, 16'd4});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("e_err_clr", key_err, 1'b0);

    // Back-to-back blocks until the narrow counter wraps past 15.
    for (int b = 0; b < 13; b++) begin
      send({4{32'(b) ^ 32'h5a5a0000}});
      wait_code(3'b100, 20);
      @(negedge clk);
    end
    chk("wrap_wide", blocks, 16'd17);
    chk("wrap_small", s_blocks, 4'd1);

    // Asynchronous reset in the middle of a block.
    send(128'h0badc0de_0badc0de_0badc0de_0badc0de);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst", {fsm, core_count, start_ready, out_valid, busy, key_err, blocks, to0},
        {3'b000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
